uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: runtime frame config (5-9 data bits, parity, 1/2 stop),
// break detection and an output FIFO with valid/ready and per-entry error flags.
module uart_rx_param #(
    parameter int unsigned CLK_DIV           = 4,
    parameter int unsigned OVERSAMPLE        = 16,
    parameter int unsigned MAX_DATABITS      = 9,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned WIDTH_CONFIG_ADDR = 2,
    parameter int unsigned WIDTH_CONFIG_DATA = 8,
    parameter logic [WIDTH_CONFIG_ADDR-1:0] CFG_ADDR = 2'b01
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in,
    input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    input  logic                         c_valid,
    input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_ready,
    output logic [MAX_DATABITS-1:0]      out,
    output logic [2:0]                   out_err,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         overrun
);
    localparam int unsigned TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PH_W     = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W    = $clog2(MAX_DATABITS + 1);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned MID      = OVERSAMPLE / 2;
    localparam int unsigned RST_BITS = (MAX_DATABITS < 8) ? MAX_DATABITS : 8;

    typedef struct packed {
        logic                    brk;
        logic                    frm;
        logic                    par;
        logic [MAX_DATABITS-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    logic [1:0]              sync_q, sync_d;
    logic                    rx_prev_q, rx_prev_d;
    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    state_t                  state_q, state_d;
    logic [1:0]              samp_q, samp_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic [MAX_DATABITS-1:0] shreg_q, shreg_d;
    logic                    par_bit_q, par_bit_d;
    logic                    stop0_q, stop0_d;
    logic                    frm_q, frm_d;
    logic [1:0]              par_mode_q, par_mode_d;
    logic                    two_stop_q, two_stop_d;
    logic [BIT_W-1:0]        nbits_q, nbits_d;
    logic                    pend_q, pend_d;
    entry_t                  pend_ent_q, pend_ent_d;
    entry_t                  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    entry_t                  head_q, head_d;
    logic                    out_valid_q, out_valid_d;
    logic                    overrun_q, overrun_d;
    logic                    c_ready_q, c_ready_d;

    logic       rx_s, tick_c, vote_ev, vote, par_en, cfg_acc;
    logic       pop, push_ok, fe, stop0_now, brk, perr;
    logic [2:0] cfg_fld;
    logic       unused_cfg_bits;

    assign unused_cfg_bits = ^c_data[WIDTH_CONFIG_DATA-1:6];

    assign rx_s    = sync_q[1];
    assign tick_c  = (tick_q == TICK_W'(CLK_DIV - 1));
    assign vote_ev = tick_c && (phase_q == PH_W'(MID + 1));
    assign vote    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);
    assign par_en  = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);

    // Synchroniser, tick divider and configuration register
    always_comb begin
        sync_d     = {sync_q[0], in};
        rx_prev_d  = rx_s;
        tick_d     = tick_c ? '0 : tick_q + TICK_W'(1);
        cfg_acc    = c_valid && c_ready_q && (c_addr == CFG_ADDR);
        cfg_fld    = c_data[5:3];
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        nbits_d    = nbits_q;
        if (cfg_acc) begin
            par_mode_d = c_data[1:0];
            two_stop_d = c_data[2];
            if (cfg_fld > 3'd4 || (32'(cfg_fld) + 32'd5) > MAX_DATABITS)
                nbits_d = BIT_W'(MAX_DATABITS);
            else
                nbits_d = BIT_W'(32'(cfg_fld) + 32'd5);
        end
    end

    // Frame FSM: every decision is taken on the third mid-bit sample
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        par_bit_d  = par_bit_q;
        stop0_d    = stop0_q;
        frm_d      = frm_q;
        pend_d     = 1'b0;
        pend_ent_d = pend_ent_q;
        fe         = frm_q | ~vote;
        stop0_now  = stop_cnt_q ? stop0_q : vote;
        brk        = ~(|shreg_q) & ~(par_en & par_bit_q) & ~stop0_now;
        perr       = par_en & ~brk & ((^shreg_q ^ par_bit_q) != (par_mode_q == 2'b10));
        if (tick_c)
            phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : phase_q + PH_W'(1);
        if (tick_c && phase_q >= PH_W'(MID - 1) && phase_q <= PH_W'(MID + 1))
            samp_d = {samp_q[0], rx_s};
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    phase_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (vote_ev) begin
                    if (vote) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        bit_cnt_d  = '0;
                        shreg_d    = '0;
                        frm_d      = 1'b0;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (vote_ev) begin
                    shreg_d   = shreg_q | (MAX_DATABITS'(vote) << bit_cnt_q);
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == nbits_q - BIT_W'(1))
                        state_d = par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (vote_ev) begin
                    par_bit_d = vote;
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (vote_ev) begin
                    frm_d = fe;
                    if (!stop_cnt_q) stop0_d = vote;
                    if (!two_stop_q || stop_cnt_q) begin
                        pend_d     = 1'b1;
                        pend_ent_d = '{brk: brk, frm: fe, par: perr, data: shreg_q};
                        state_d    = rx_s ? IDLE : WAIT_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        c_ready_d = (state_d == IDLE);
    end

    // Output FIFO; a config write flushes it, including any entry about to be pushed
    always_comb begin
        pop       = out_valid_q && out_ready && !cfg_acc;
        push_ok   = pend_q && !cfg_acc && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
        overrun_d = cfg_acc ? 1'b0 : (overrun_q | (pend_q & ~cfg_acc & ~push_ok));
        wr_ptr_d  = cfg_acc ? '0 : (push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q);
        rd_ptr_d  = cfg_acc ? '0 : (pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q);
        count_d   = cfg_acc ? '0 : count_q + CNT_W'(push_ok) - CNT_W'(pop);
        out_valid_d = (count_d != '0);
        if (count_d == '0)
            head_d = '0;
        else if (push_ok && (count_q == CNT_W'(pop)))
            head_d = pend_ent_q;
        else
            head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= pend_ent_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            tick_q      <= '0;
            phase_q     <= '0;
            state_q     <= IDLE;
            samp_q      <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            shreg_q     <= '0;
            par_bit_q   <= 1'b0;
            stop0_q     <= 1'b1;
            frm_q       <= 1'b0;
            par_mode_q  <= 2'b00;
            two_stop_q  <= 1'b0;
            nbits_q     <= BIT_W'(RST_BITS);
            pend_q      <= 1'b0;
            pend_ent_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            head_q      <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            c_ready_q   <= 1'b1;
        end else begin
            sync_q      <= sync_d;
            rx_prev_q   <= rx_prev_d;
            tick_q      <= tick_d;
            phase_q     <= phase_d;
            state_q     <= state_d;
            samp_q      <= samp_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            shreg_q     <= shreg_d;
            par_bit_q   <= par_bit_d;
            stop0_q     <= stop0_d;
            frm_q       <= frm_d;
            par_mode_q  <= par_mode_d;
            two_stop_q  <= two_stop_d;
            nbits_q     <= nbits_d;
            pend_q      <= pend_d;
            pend_ent_q  <= pend_ent_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            c_ready_q   <= c_ready_d;
        end
    end

    assign c_ready   = c_ready_q;
    assign out       = head_q.data;
    assign out_err   = {head_q.brk, head_q.frm, head_q.par};
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: a serial driver queues expected entries computed
// from the frame rules; a monitor pops and compares whenever the DUT hands over an entry.
module tb_uart_rx_param;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MAXB       = 9;
    localparam int unsigned DEPTH      = 8;
    localparam int unsigned BIT_CLKS   = CLK_DIV * OVERSAMPLE;

    logic       clk;
    logic       rst;
    logic       in;
    logic [1:0] c_addr;
    logic       c_valid;
    logic [7:0] c_data;
    logic       c_ready;
    logic [8:0] out;
    logic [2:0] out_err;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;

    int checks = 0;
    int fails  = 0;
    logic [11:0] exp_q[$];
    int cur_nb = 8;
    int cur_pm = 0;
    int cur_ns = 1;

    uart_rx_param #(
        .CLK_DIV(CLK_DIV), .OVERSAMPLE(OVERSAMPLE), .MAX_DATABITS(MAXB), .FIFO_DEPTH(DEPTH),
        .WIDTH_CONFIG_ADDR(2), .WIDTH_CONFIG_DATA(8), .CFG_ADDR(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .in(in), .c_addr(c_addr), .c_valid(c_valid), .c_data(c_data),
        .c_ready(c_ready), .out(out), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected entry
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_entry: got 0x%0h with no entry expected",
                             {out_err, out});
                end else begin
                    e = exp_q.pop_front();
                    check("entry", 32'({out_err, out}), 32'(e));
                end
            end
        end
    end

    function automatic void apply_cfg(input logic [7:0] c);
        int f;
        f      = int'(c[5:3]);
        cur_pm = int'(c[1:0]);
        cur_ns = c[2] ? 2 : 1;
        cur_nb = (f > 4 || f + 5 > int'(MAXB)) ? int'(MAXB) : f + 5;
    endfunction

    task automatic drive_bit(input logic v);
        in = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input int data, input int nb, input int pm, input int ns,
                              input bit bad_par, input bit bad_stop, input bit expect_entry);
        int   d;
        bit   pen, pbit, stop0, brk, frm, perr;
        d     = data & ((1 << nb) - 1);
        pen   = (pm == 1) || (pm == 2);
        pbit  = ($countones(d) % 2 == 1) ^ (pm == 2) ^ bad_par;
        stop0 = !bad_stop;
        brk   = (d == 0) && (!pen || !pbit) && !stop0;
        frm   = !stop0;
        perr  = pen && bad_par && !brk;
        if (expect_entry) exp_q.push_back({brk, frm, perr, 9'(d)});
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(1'((d >> i) & 1));
        if (pen) drive_bit(pbit);
        drive_bit(stop0);
        if (ns == 2) drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic send(input int data, input bit bad_par, input bit expect_entry);
        send_frame(data, cur_nb, cur_pm, cur_ns, bad_par, 1'b0, expect_entry);
    endtask

    task automatic wait_cready(input logic lvl, input string name);
        int n = 0;
        while (c_ready !== lvl && n < 14 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(c_ready), 32'(lvl));
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
        wait_cready(1'b1, "cfg_wait_ready");
        c_addr  = addr;
        c_data  = data;
        c_valid = 1'b1;
        @(negedge clk);
        c_valid = 1'b0;
        if (addr == 2'b01) begin
            apply_cfg(data);
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_c_ready"}, 32'(c_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_out_err"}, 32'(out_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        in = 1'b1; rst = 1'b0; c_valid = 1'b0; c_addr = 2'b00; c_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // 8N1 frame; FSM busy mid-frame
        fork
            send(32'hA5, 1'b0, 1'b1);
            begin
                repeat (3 * BIT_CLKS) @(negedge clk);
                check("busy_c_ready", 32'(c_ready), 32'd0);
            end
        join

        // 8E1 with wrong then right parity bit
        cfg_write(2'b01, 8'h19);
        send(32'h03, 1'b1, 1'b1);
        send(32'h03, 1'b0, 1'b1);

        // other address must be ignored: frame still decoded as 8E1
        cfg_write(2'b10, 8'h1A);
        send(32'h96, 1'b0, 1'b1);
        cfg_write(2'b01, 8'h18);

        // false start
        in = 1'b0;
        repeat (16) @(negedge clk);
        in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("false_start_c_ready", 32'(c_ready), 32'd1);
        check("false_start_no_entry", 32'(out_valid), 32'd0);
        send(32'h5A, 1'b0, 1'b1);

        // break: one entry, then held off until the line returns high
        exp_q.push_back({3'b110, 9'h000});
        in = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        check("break_wait_idle", 32'(c_ready), 32'd0);
        check("break_one_entry", 32'(exp_q.size()), 32'd0);
        in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("break_back_idle", 32'(c_ready), 32'd1);
        send(32'h33, 1'b0, 1'b1);

        // overrun: 9 frames into 8 entries
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(i, 1'b0, 1'b1);
        send(32'h09, 1'b0, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        check("full_head", 32'({out_valid, out}), 32'h201);
        // pop exactly on the clock the next frame is pushed into the full FIFO
        fork
            send(32'h0A, 1'b0, 1'b1);
            begin
                wait_cready(1'b0, "full_frame_start");
                wait_cready(1'b1, "full_frame_end");
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        check("overrun_sticky", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_done", 32'(exp_q.size()), 32'd0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // config request held through a frame; that frame's entry is flushed
        fork
            send(32'h77, 1'b0, 1'b0);
            begin
                repeat (3 * BIT_CLKS) @(negedge clk);
                check("cfg_blocked", 32'(c_ready), 32'd0);
                c_addr  = 2'b01;
                c_data  = 8'h16;
                c_valid = 1'b1;
                wait_cready(1'b1, "cfg_held_ready");
                @(negedge clk);
                c_valid = 1'b0;
                apply_cfg(8'h16);
                exp_q.delete();
            end
        join
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_overrun", 32'(overrun), 32'd0);
        send(32'h41, 1'b0, 1'b1);

        // reset mid-frame with a held entry
        out_ready = 1'b0;
        send(32'h22, 1'b0, 1'b0);
        check("held_entry", 32'({out_valid, out}), 32'h222);
        in = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        rst = 1'b0;
        in  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midframe_reset");
        apply_cfg(8'h18);
        exp_q.delete();
        out_ready = 1'b1;
        send(32'hC3, 1'b0, 1'b1);

        // randomized configurations and frames
        for (int k = 0; k < 10; k++) begin
            logic [7:0] c;
            int data;
            bit bp, bs;
            c    = 8'($urandom);
            cfg_write(2'b01, c);
            data = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(0, 511));
            bp   = ($urandom_range(0, 3) == 0);
            bs   = ($urandom_range(0, 3) == 0);
            send_frame(data, cur_nb, cur_pm, cur_ns, bp, bs, 1'b1);
        end

        repeat (BIT_CLKS) @(negedge clk);
        check("final_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
